// File: rtl/rf_write_ctrl.sv
// rtl/rf_write_ctrl.sv - register file write controller: post-reset clear, two-requester writeback arbiter, busy scoreboard
module rf_write_ctrl #(
  parameter int CLEAR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [1:0] req0_idx,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_idx,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       rsv_valid,
  input  logic [1:0] rsv_idx,
  output logic       rf_we,
  output logic [1:0] rf_idx,
  output logic [7:0] rf_data,
  output logic       rf_reset,
  output logic [3:0] busy,
  output logic       init_done
);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;
  localparam logic [3:0] CNT_LAST = 4'(CLEAR_CYCLES - 1);

  logic       state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;
  logic       rf_we_q, rf_we_d;
  logic [1:0] rf_idx_q, rf_idx_d;
  logic [7:0] rf_data_q, rf_data_d;
  logic [3:0] busy_q, busy_d;

  logic       run;
  logic       grant0, grant1;
  logic       hs0, hs1;
  logic [3:0] set_mask, clr_mask;

  assign run = (state_q == ST_RUN);

  // ptr_q names the requester granted last; the other one wins a tie.
  always_comb begin
    grant0 = run & req0_valid & (~req1_valid | ptr_q);
    grant1 = run & req1_valid & (~req0_valid | ~ptr_q);
    hs0    = grant0;
    hs1    = grant1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    rf_we_d   = 1'b0;
    rf_idx_d  = rf_idx_q;
    rf_data_d = rf_data_q;
    if (hs0) begin
      ptr_d     = 1'b0;
      rf_we_d   = 1'b1;
      rf_idx_d  = req0_idx;
      rf_data_d = req0_data;
    end else if (hs1) begin
      ptr_d     = 1'b1;
      rf_we_d   = 1'b1;
      rf_idx_d  = req1_idx;
      rf_data_d = req1_data;
    end
  end

  // A reservation landing on the index being written back keeps it busy.
  always_comb begin
    set_mask = 4'b0000;
    clr_mask = 4'b0000;
    if (run && rsv_valid) begin
      set_mask[rsv_idx] = 1'b1;
    end
    if (hs0) begin
      clr_mask[req0_idx] = 1'b1;
    end else if (hs1) begin
      clr_mask[req1_idx] = 1'b1;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= 4'd0;
      ptr_q     <= 1'b1;
      rf_we_q   <= 1'b0;
      rf_idx_q  <= 2'd0;
      rf_data_q <= 8'd0;
      busy_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rf_we_q   <= rf_we_d;
      rf_idx_q  <= rf_idx_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rf_we      = rf_we_q;
  assign rf_idx     = rf_idx_q;
  assign rf_data    = rf_data_q;
  assign rf_reset   = (state_q == ST_CLEAR);
  assign busy       = busy_q;
  assign init_done  = run;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb/tb_rf_write_ctrl.sv - directed self-checking bench for rf_write_ctrl
module tb_rf_write_ctrl;

  logic       clk;
  logic       reset_n;
  logic       req0_valid;
  logic [1:0] req0_idx;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_idx;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       rsv_valid;
  logic [1:0] rsv_idx;
  logic       rf_we;
  logic [1:0] rf_idx;
  logic [7:0] rf_data;
  logic       rf_reset;
  logic [3:0] busy;
  logic       init_done;

  int n_cmp;
  int n_err;

  rf_write_ctrl #(.CLEAR_CYCLES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_idx   (req0_idx),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_idx   (req1_idx),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rsv_valid  (rsv_valid),
    .rsv_idx    (rsv_idx),
    .rf_we      (rf_we),
    .rf_idx     (rf_idx),
    .rf_data    (rf_data),
    .rf_reset   (rf_reset),
    .busy       (busy),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] cont_data [4];
  logic       cont_g0   [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    cont_data[0] = 8'h11; cont_data[1] = 8'h22; cont_data[2] = 8'h11; cont_data[3] = 8'h22;
    cont_g0[0] = 1'b1; cont_g0[1] = 1'b0; cont_g0[2] = 1'b1; cont_g0[3] = 1'b0;

    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req0_idx   = 2'd0;
    req0_data  = 8'h00;
    req1_valid = 1'b0;
    req1_idx   = 2'd0;
    req1_data  = 8'h00;
    rsv_valid  = 1'b0;
    rsv_idx    = 2'd0;
    #3;
    check("rst_rf_reset", rf_reset, 1);
    check("rst_init_done", init_done, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_busy", busy, 4'b0000);
    check("rst_rf_idx", rf_idx, 0);
    check("rst_rf_data", rf_data, 0);
    tick();
    tick();

    // release between edges; req0_valid held high across CLEAR
    @(posedge clk); #2; reset_n = 1'b1;
    tick();
    check("clr1_rf_reset", rf_reset, 1);
    check("clr1_init_done", init_done, 0);
    check("clr1_req0_ready", req0_ready, 0);
    check("clr1_rf_we", rf_we, 0);
    tick();
    check("clr2_rf_reset", rf_reset, 0);
    check("clr2_init_done", init_done, 1);
    check("clr2_rf_we", rf_we, 0);
    check("run_req0_ready", req0_ready, 1);
    req0_valid = 1'b0;

    // contention: pointer resets to requester 1, so requester 0 goes first
    req0_valid = 1'b1; req0_idx = 2'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_idx = 2'd0; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_req0_ready", req0_ready, cont_g0[i]);
      check("cont_req1_ready", req1_ready, !cont_g0[i]);
      tick();
      check("cont_rf_we", rf_we, 1);
      check("cont_rf_data", rf_data, cont_data[i]);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("idle_readys", {req0_ready, req1_ready}, 2'b00);
    tick();
    check("cont_end_rf_we", rf_we, 0);

    // single write
    req0_valid = 1'b1; req0_idx = 2'd2; req0_data = 8'hA5;
    #1;
    check("single_req0_ready", req0_ready, 1);
    check("single_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("single_rf_we", rf_we, 1);
    check("single_rf_idx", rf_idx, 2);
    check("single_rf_data", rf_data, 8'hA5);
    tick();
    check("single_after_we", rf_we, 0);
    check("single_hold_idx", rf_idx, 2);
    check("single_hold_data", rf_data, 8'hA5);

    // scoreboard
    rsv_valid = 1'b1; rsv_idx = 2'd3;
    tick();
    rsv_valid = 1'b0;
    check("sb_rsv3", busy, 4'b1000);
    req1_valid = 1'b1; req1_idx = 2'd3; req1_data = 8'h33;
    rsv_valid  = 1'b1; rsv_idx  = 2'd3;
    #1;
    check("sb_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    rsv_valid  = 1'b0;
    check("sb_same_idx", busy, 4'b1000);
    check("sb_wr_data", rf_data, 8'h33);
    req0_valid = 1'b1; req0_idx = 2'd3; req0_data = 8'h44;
    tick();
    req0_valid = 1'b0;
    check("sb_clear3", busy, 4'b0000);
    rsv_valid = 1'b1; rsv_idx = 2'd2;
    tick();
    check("sb_rsv2", busy, 4'b0100);
    rsv_idx = 2'd0;
    req1_valid = 1'b1; req1_idx = 2'd2; req1_data = 8'h66;
    tick();
    rsv_valid  = 1'b0;
    req1_valid = 1'b0;
    check("sb_diff_idx", busy, 4'b0001);

    // async reset mid-burst
    req0_valid = 1'b1; req0_idx = 2'd1; req0_data = 8'h55;
    #1;
    check("mb_req0_ready", req0_ready, 1);
    tick();
    check("mb_rf_we", rf_we, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mb_rst_rf_we", rf_we, 0);
    check("mb_rst_busy", busy, 4'b0000);
    check("mb_rst_readys", {req0_ready, req1_ready}, 2'b00);
    check("mb_rst_rf_reset", rf_reset, 1);
    check("mb_rst_init_done", init_done, 0);
    @(posedge clk); #2; reset_n = 1'b1;
    tick();
    check("mb_clr1_rf_reset", rf_reset, 1);
    check("mb_clr1_rf_we", rf_we, 0);
    tick();
    check("mb_clr2_rf_reset", rf_reset, 0);
    check("mb_clr2_init_done", init_done, 1);
    check("mb_clr2_rf_we", rf_we, 0);
    check("mb_run_req0_ready", req0_ready, 1);
    req0_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_ctrl.md
RF_WRITE_CTRL -- requirements
Module: rf_write_ctrl

Interface
REQ-001 SHALL have parameter: CLEAR_CYCLES, default 2, number of clk edges rf_reset stays high after reset_n deasserts (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0_valid  input  1, req0_idx  input  2, req0_data  input  8  (writeback requester 0: ALU).
REQ-005 SHALL have port: req0_ready  output  1  grant to requester 0.
REQ-006 SHALL have ports: req1_valid  input  1, req1_idx  input  2, req1_data  input  8  (writeback requester 1: load unit).
REQ-007 SHALL have port: req1_ready  output  1  grant to requester 1.
REQ-008 SHALL have ports: rsv_valid  input  1, rsv_idx  input  2  (issue stage reserves a destination register).
REQ-009 SHALL have ports: rf_we  output  1, rf_idx  output  2, rf_data  output  8  (drive register file write_enable, reg_write, write_data).
REQ-010 SHALL have port: rf_reset  output  1  drives register file synchronous active-high reset.
REQ-011 SHALL have ports: busy  output  4  per-register pending-write flags; init_done  output  1  high in RUN.

Function
REQ-012 SHALL implement a 2-state FSM: CLEAR, RUN; reset_n low forces CLEAR with clear counter = 0.
REQ-013 In CLEAR, rf_reset SHALL be 1 (combinational from state, so also high during reset_n low) and counter SHALL increment each posedge.
REQ-014 CLEAR SHALL transition to RUN on the posedge where counter = CLEAR_CYCLES-1; RUN is left only by reset_n low.
REQ-015 Outside RUN, req0_ready, req1_ready SHALL be 0, rsv_valid SHALL be ignored, rf_we SHALL be 0.
REQ-016 In RUN, arbitration SHALL be combinational: only one valid -> that requester ready; both valid -> requester not granted most recently ready; neither -> both ready 0.
REQ-017 At most one of req0_ready/req1_ready SHALL be 1 in any cycle; ready SHALL never be 1 with its valid 0.
REQ-018 Last-grant pointer SHALL update only on a handshake (valid & ready); reset value points to requester 1, so requester 0 wins the first contention.
REQ-019 A handshake SHALL be accepted at the posedge; the following cycle rf_we = 1 with rf_idx/rf_data = the accepted idx/data (latency 1, throughput 1 write/cycle).
REQ-020 Without a handshake, rf_we SHALL be 0 next cycle and rf_idx/rf_data SHALL hold their previous values.
REQ-021 Requesters SHALL hold valid/idx/data stable until ready; dropping valid before grant is permitted and cancels the request.
REQ-022 busy[i] SHALL set at posedge when rsv_valid=1 and rsv_idx=i in RUN.
REQ-023 busy[i] SHALL clear at the posedge accepting a handshake with idx=i.
REQ-024 Simultaneous set and clear on the same index SHALL leave busy[i]=1 (new reservation wins); different indices both take effect.
REQ-025 Handshake to a register with busy=0 SHALL be accepted normally (busy stays 0); no error flagged.
REQ-026 init_done SHALL equal (state == RUN).

Reset
REQ-027 On reset_n low, asynchronously: state=CLEAR, counter=0, rf_we=0, rf_idx=0, rf_data=0, busy=0, pointer=1; readys=0, rf_reset=1, init_done=0.
REQ-028 Reset mid-operation SHALL drop any accepted-but-unwritten write and all reservations.
REQ-029 Deassertion SHALL be honoured on the next posedge; no synchronizer inside the block.

Verification
REQ-030 Reset release, CLEAR_CYCLES=2: rf_reset high during reset and 2 edges after, then 0; init_done rises same cycle; no rf_we during CLEAR even with req0_valid=1.
REQ-031 Single write: req0 idx=2 data=8'hA5 in RUN -> req0_ready=1 same cycle; next cycle rf_we=1, rf_idx=2, rf_data=8'hA5; following cycle rf_we=0.
REQ-032 Contention: both valid continuously for 4 cycles (req0 data 8'h11, req1 data 8'h22) -> grants 0,1,0,1; rf_data sequence 11,22,11,22 one cycle later.
REQ-033 Scoreboard: rsv idx=3 -> busy=4'b1000; req1 write idx=3 accepted with rsv idx=3 same cycle -> busy stays 4'b1000; next write idx=3 -> 4'b0000.
REQ-034 Async reset mid-burst: reset_n low between edges while req0 granted -> rf_we=0, busy=0, readys=0 immediately; post-release sequence matches REQ-030.
